// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: instruction address width, default stack depth
// and the per-cycle operation selected by the return stack.
package cpu_pkg;

  localparam int ADDR_W   = 10;
  localparam int RS_DEPTH = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_REPLACE,
    OP_PUSH,
    OP_POP,
    OP_LOAD
  } rs_op_t;

endpackage

// File: rtl/return_stack_if.sv
// Bus between the PC/sequencer side (master) and the return-address stack (slave).
interface return_stack_if #(
  parameter int DEPTH = cpu_pkg::RS_DEPTH,
  parameter int AW    = cpu_pkg::ADDR_W
);

  logic [AW-1:0]          rp;
  logic                   branch;
  logic                   jump2sub;
  logic                   retFsub;
  logic                   lr_ld;
  logic [AW-1:0]          lr_din;
  logic                   err_clr;
  logic [AW-1:0]          rl;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   full;
  logic                   ovf;
  logic                   unf;

  modport master (
    output rp, branch, jump2sub, retFsub, lr_ld, lr_din, err_clr,
    input  rl, count, empty, full, ovf, unf
  );

  modport slave (
    input  rp, branch, jump2sub, retFsub, lr_ld, lr_din, err_clr,
    output rl, count, empty, full, ovf, unf
  );

endinterface

// File: rtl/return_stack_mem.sv
// DEPTH x AW register file: one synchronous write port, one asynchronous read port.
// Contents are never reset; the stack masks unwritten entries through its count.
module return_stack_mem #(
  parameter int DEPTH = cpu_pkg::RS_DEPTH,
  parameter int AW    = cpu_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_stack.sv
// Circular return-address stack feeding the PC link value rl, with software
// overwrite of the top entry and sticky overflow/underflow flags.
module return_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          start,
  return_stack_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] tp_q, tp_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          push, pop, grow, is_empty, is_full;
  logic          we;
  logic [PW-1:0] waddr;
  logic [AW-1:0] wdata, ret, rdata;
  rs_op_t        op;

  assign push     = bus.jump2sub & ~bus.branch & ~start;
  assign pop      = bus.retFsub  & ~bus.branch & ~start;
  assign ret      = bus.rp + AW'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  always_comb begin
    op = OP_HOLD;
    if (!start) begin
      if (push && pop)     op = OP_REPLACE;
      else if (push)       op = OP_PUSH;
      else if (pop)        op = OP_POP;
      else if (bus.lr_ld)  op = OP_LOAD;
    end
  end

  // Any write into an empty stack, and every plain push, advances tp ("grow");
  // a push while full overwrites the oldest slot instead of counting up.
  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    ovf_d   = ovf_q & ~bus.err_clr;
    unf_d   = unf_q & ~bus.err_clr;
    we      = 1'b0;
    waddr   = tp_q;
    wdata   = ret;
    grow    = 1'b0;
    case (op)
      OP_REPLACE: begin
        if (is_empty) grow = 1'b1;
        else          we   = 1'b1;
      end
      OP_PUSH: grow = 1'b1;
      OP_POP: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          tp_d    = tp_q - PW'(1);
          count_d = count_q - CW'(1);
        end
      end
      OP_LOAD: begin
        wdata = bus.lr_din;
        if (is_empty) grow = 1'b1;
        else          we   = 1'b1;
      end
      default: ;
    endcase
    if (grow) begin
      tp_d  = tp_q + PW'(1);
      waddr = tp_q + PW'(1);
      we    = 1'b1;
      if (is_full) ovf_d   = 1'b1;
      else         count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      tp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  return_stack_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (tp_q),
    .rdata (rdata)
  );

  assign bus.rl    = is_empty ? '0 : rdata;
  assign bus.count = count_q;
  assign bus.empty = is_empty;
  assign bus.full  = is_full;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: directed scenarios then random traffic,
// compared every cycle against a queue-based model of a bounded LIFO.
module tb_return_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 10;

  logic clk;
  logic start;

  int numAsserts;
  int numFails;

  // Reference model: the queue holds valid return addresses, oldest first.
  int unsigned stackQ[$];
  logic        mOvf;
  logic        mUnf;

  return_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numAsserts++;
    assert (obs === exp)
    else begin
      numFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic s, input logic br, input logic j, input logic r,
                           input logic ld, input int unsigned rpv, input int unsigned din,
                           input logic ec);
    int unsigned retv;
    logic setO, setU, doPush, doPop;
    if (s) begin
      stackQ.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
      return;
    end
    retv   = (rpv + 1) % (1 << AW);
    doPush = j && !br;
    doPop  = r && !br;
    setO   = 1'b0;
    setU   = 1'b0;
    if (doPush && doPop) begin
      if (stackQ.size() == 0) stackQ.push_back(retv);
      else stackQ[stackQ.size()-1] = retv;
    end else if (doPush) begin
      if (stackQ.size() == DEPTH) begin
        void'(stackQ.pop_front());
        setO = 1'b1;
      end
      stackQ.push_back(retv);
    end else if (doPop) begin
      if (stackQ.size() == 0) setU = 1'b1;
      else void'(stackQ.pop_back());
    end else if (ld) begin
      if (stackQ.size() == 0) stackQ.push_back(din);
      else stackQ[stackQ.size()-1] = din;
    end
    mOvf = setO | (mOvf & !ec);
    mUnf = setU | (mUnf & !ec);
  endtask

  task automatic checkOutput(input string tag);
    int unsigned expRl;
    expRl = (stackQ.size() == 0) ? 0 : stackQ[stackQ.size()-1];
    checkValue({tag, ".rl"},    32'(bus.rl),    32'(expRl));
    checkValue({tag, ".count"}, 32'(bus.count), 32'(stackQ.size()));
    checkValue({tag, ".empty"}, 32'(bus.empty), 32'(stackQ.size() == 0));
    checkValue({tag, ".full"},  32'(bus.full),  32'(stackQ.size() == DEPTH));
    checkValue({tag, ".ovf"},   32'(bus.ovf),   32'(mOvf));
    checkValue({tag, ".unf"},   32'(bus.unf),   32'(mUnf));
  endtask

  // Drive one cycle of inputs, advance the model, clock, then check #1 after the edge.
  task automatic applyStimulus(input string tag, input logic s, input logic br,
                               input logic j, input logic r, input logic ld,
                               input logic [AW-1:0] rpv, input logic [AW-1:0] din,
                               input logic ec);
    start        = s;
    bus.branch   = br;
    bus.jump2sub = j;
    bus.retFsub  = r;
    bus.lr_ld    = ld;
    bus.rp       = rpv;
    bus.lr_din   = din;
    bus.err_clr  = ec;
    modelStep(s, br, j, r, ld, int'(rpv), int'(din), ec);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic push(input string tag, input logic [AW-1:0] rpv);
    applyStimulus(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rpv, '0, 1'b0);
  endtask

  task automatic pop(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    numAsserts = 0;
    numFails   = 0;
    mOvf = 1'b0;
    mUnf = 1'b0;
    start = 1'b0;
    bus.rp = '0; bus.branch = 1'b0; bus.jump2sub = 1'b0; bus.retFsub = 1'b0;
    bus.lr_ld = 1'b0; bus.lr_din = '0; bus.err_clr = 1'b0;

    // Reset then idle
    applyStimulus("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkValue("reset_rl_const", 32'(bus.rl), 32'h0);
    idle("idle");

    // Call / return
    push("call", 10'h012);
    checkValue("call_rl_const", 32'(bus.rl), 32'h013);
    pop("return");
    checkValue("return_empty_const", 32'(bus.empty), 32'h1);

    // Nesting with address wrap
    push("nest1", 10'h100);
    push("nest2", 10'h200);
    push("nest3", 10'h3FF);
    checkValue("wrap_rl_const", 32'(bus.rl), 32'h000);
    pop("unnest1");
    checkValue("unnest1_rl_const", 32'(bus.rl), 32'h201);
    pop("unnest2");
    checkValue("unnest2_rl_const", 32'(bus.rl), 32'h101);
    pop("unnest3");

    // Overflow: nine pushes, the first return address is lost
    for (int i = 0; i <= 8; i++) push("ovf_push", 10'(i));
    checkValue("ovf_rl_const", 32'(bus.rl), 32'h009);
    checkValue("ovf_flag_const", 32'(bus.ovf), 32'h1);
    for (int i = 0; i < 7; i++) pop("ovf_pop");
    checkValue("ovf_last_rl_const", 32'(bus.rl), 32'h002);
    pop("ovf_pop8");
    // Underflow pop with err_clr: unf set wins, ovf is cleared
    applyStimulus("unf_clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
    checkValue("unf_sticky_const", 32'(bus.unf), 32'h1);
    checkValue("ovf_cleared_const", 32'(bus.ovf), 32'h0);
    applyStimulus("err_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

    // Priority and simultaneous events
    applyStimulus("branch_blocks", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h055, '0, 1'b0);
    applyStimulus("ld_empty", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 10'h050, 1'b0);
    checkValue("ld_empty_rl_const", 32'(bus.rl), 32'h050);
    applyStimulus("replace", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h070, '0, 1'b0);
    checkValue("replace_rl_const", 32'(bus.rl), 32'h071);
    push("pre_ld", 10'h123);
    applyStimulus("ld_top", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 10'h2AA, 1'b0);
    checkValue("ld_top_rl_const", 32'(bus.rl), 32'h2AA);
    applyStimulus("ld_vs_push", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h010, 10'h333, 1'b0);
    applyStimulus("replace_empty_pre", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus("replace_empty", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h044, '0, 1'b0);
    checkValue("replace_empty_unf_const", 32'(bus.unf), 32'h0);

    // Reset mid-operation overrides a push
    for (int i = 0; i < 4; i++) push("fill5", 10'(10 + i));
    applyStimulus("reset_mid", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h0AA, 10'h0BB, 1'b0);
    checkValue("reset_mid_count_const", 32'(bus.count), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus("random",
                    ($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 1) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 4) == 0),
                    10'($urandom),
                    10'($urandom),
                    ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
